// File: rtl/lenet_ctrl_pkg.sv
// rtl/lenet_ctrl_pkg.sv - shared consumer FSM encodings, bank index type and start-delay default
package lenet_ctrl_pkg;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_WAIT = 2'd1,
        C_RUN  = 2'd2
    } cons_state_t;

    typedef logic bank_idx_t;

    localparam int START_DELAY_DEF = 3;
    localparam int START_TIMER_W   = 4;

endpackage

// File: rtl/ifm_bank_scheduler_if.sv
// rtl/ifm_bank_scheduler_if.sv - producer/consumer bank handshake bundle
// stall_cycles is present only with IFM_BANK_SCHED_PERF_EN defined.
interface ifm_bank_scheduler_if #(
    parameter int FRAME_CNT_W = 3
`ifdef IFM_BANK_SCHED_PERF_EN
    ,
    parameter int PERF_CNT_W  = 16
`endif
);
    logic                   prod_done;
    logic                   prod_hold;
    logic                   prod_bank_sel;
    logic                   cons_start;
    logic                   cons_done;
    logic                   cons_bank_sel;
    logic                   cons_busy;
    logic [1:0]             bank_full;
    logic [FRAME_CNT_W-1:0] frames_consumed;
    logic                   layer_done;
    logic                   err_overrun;
`ifdef IFM_BANK_SCHED_PERF_EN
    logic [PERF_CNT_W-1:0]  stall_cycles;

    modport slave (
        input  prod_done, cons_done,
        output prod_hold, prod_bank_sel, cons_start, cons_bank_sel, cons_busy,
               bank_full, frames_consumed, layer_done, err_overrun, stall_cycles
    );
    modport master (
        output prod_done, cons_done,
        input  prod_hold, prod_bank_sel, cons_start, cons_bank_sel, cons_busy,
               bank_full, frames_consumed, layer_done, err_overrun, stall_cycles
    );
`else
    modport slave (
        input  prod_done, cons_done,
        output prod_hold, prod_bank_sel, cons_start, cons_bank_sel, cons_busy,
               bank_full, frames_consumed, layer_done, err_overrun
    );
    modport master (
        output prod_done, cons_done,
        input  prod_hold, prod_bank_sel, cons_start, cons_bank_sel, cons_busy,
               bank_full, frames_consumed, layer_done, err_overrun
    );
`endif
endinterface

// File: rtl/ifm_bank_start_timer.sv
// rtl/ifm_bank_start_timer.sv - loadable down-counter holding at zero, with zero flag
module ifm_bank_start_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/ifm_bank_scheduler.sv
// rtl/ifm_bank_scheduler.sv - ping-pong IFM bank scheduler between producer and consumer layers
// Optional stall counter enabled by IFM_BANK_SCHED_PERF_EN.
module ifm_bank_scheduler
    import lenet_ctrl_pkg::*;
#(
    parameter int NUM_FRAMES  = 6,
    parameter int FRAME_CNT_W = $clog2(NUM_FRAMES + 1),
    parameter int START_DELAY = START_DELAY_DEF
`ifdef IFM_BANK_SCHED_PERF_EN
    ,
    parameter int PERF_CNT_W  = 16
`endif
) (
    input  logic                clk,
    input  logic                reset,
    ifm_bank_scheduler_if.slave bus
);

    localparam logic [START_TIMER_W-1:0] C_LOAD = START_TIMER_W'(START_DELAY - 1);
    localparam logic [FRAME_CNT_W-1:0]   C_LAST = FRAME_CNT_W'(NUM_FRAMES - 1);

    cons_state_t            r_state;
    cons_state_t            w_state_nxt;
    logic [1:0]             r_bank_full;
    logic [1:0]             w_bank_full_nxt;
    bank_idx_t              r_prod_sel;
    bank_idx_t              r_cons_sel;
    logic [FRAME_CNT_W-1:0] r_frames;
    logic                   r_layer_done;
    logic                   r_err;
    logic                   w_prod_hold;
    logic                   w_prod_acc;
    logic                   w_cons_acc;
    logic                   w_load;
    logic                   w_start;
    logic                   w_timer_zero;
    logic                   w_last;

    assign w_prod_hold = r_bank_full[r_prod_sel];
    assign w_prod_acc  = bus.prod_done & ~w_prod_hold;
    assign w_cons_acc  = bus.cons_done & (r_state == C_RUN);
    assign w_last      = (r_frames == C_LAST);

    ifm_bank_start_timer #(
        .W (START_TIMER_W)
    ) u_start_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (C_LOAD),
        .i_en       (r_state == C_WAIT),
        .o_zero     (w_timer_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (r_bank_full[r_cons_sel]) begin
                    w_load      = 1'b1;
                    w_state_nxt = C_WAIT;
                end
            end
            C_WAIT: begin
                if (w_timer_zero) begin
                    w_start     = 1'b1;
                    w_state_nxt = C_RUN;
                end
            end
            C_RUN: begin
                if (bus.cons_done) begin
                    w_state_nxt = C_IDLE;
                end
            end
            default: w_state_nxt = C_IDLE;
        endcase
    end

    // A producer fill and a consumer drain in one cycle always hit different banks.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (w_prod_acc) begin
            w_bank_full_nxt[r_prod_sel] = 1'b1;
        end
        if (w_cons_acc) begin
            w_bank_full_nxt[r_cons_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= C_IDLE;
            r_bank_full  <= 2'b00;
            r_prod_sel   <= 1'b0;
            r_cons_sel   <= 1'b0;
            r_frames     <= '0;
            r_layer_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bank_full  <= w_bank_full_nxt;
            r_layer_done <= w_cons_acc & w_last;
            r_err        <= r_err | (bus.prod_done & w_prod_hold)
                                  | (bus.cons_done & (r_state != C_RUN));
            if (w_prod_acc) begin
                r_prod_sel <= ~r_prod_sel;
            end
            if (w_cons_acc) begin
                r_cons_sel <= ~r_cons_sel;
                r_frames   <= w_last ? '0 : r_frames + FRAME_CNT_W'(1);
            end
        end
    end

`ifdef IFM_BANK_SCHED_PERF_EN
    logic [PERF_CNT_W-1:0] r_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (r_layer_done) begin
            r_stall <= '0;
        end else if (w_prod_hold && (r_stall != '1)) begin
            r_stall <= r_stall + PERF_CNT_W'(1);
        end
    end

    assign bus.stall_cycles = r_stall;
`endif

    assign bus.prod_hold       = w_prod_hold;
    assign bus.prod_bank_sel   = r_prod_sel;
    assign bus.cons_start      = w_start;
    assign bus.cons_bank_sel   = r_cons_sel;
    assign bus.cons_busy       = (r_state == C_RUN);
    assign bus.bank_full       = r_bank_full;
    assign bus.frames_consumed = r_frames;
    assign bus.layer_done      = r_layer_done;
    assign bus.err_overrun     = r_err;

endmodule

// File: tb/tb_ifm_bank_scheduler.sv
// tb/tb_ifm_bank_scheduler.sv - directed table, corner sequences and random run against a bank-queue model
module tb_ifm_bank_scheduler;

    localparam int NUM_FRAMES  = 6;
    localparam int FRAME_CNT_W = 3;
    localparam int START_DELAY = 3;
`ifdef IFM_BANK_SCHED_PERF_EN
    localparam int PERF_CNT_W  = 16;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

`ifdef IFM_BANK_SCHED_PERF_EN
    ifm_bank_scheduler_if #(.FRAME_CNT_W(FRAME_CNT_W), .PERF_CNT_W(PERF_CNT_W)) bus ();
    ifm_bank_scheduler #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_CNT_W(FRAME_CNT_W),
        .START_DELAY(START_DELAY),
        .PERF_CNT_W (PERF_CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
`else
    ifm_bank_scheduler_if #(.FRAME_CNT_W(FRAME_CNT_W)) bus ();
    ifm_bank_scheduler #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_CNT_W(FRAME_CNT_W),
        .START_DELAY(START_DELAY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
`endif

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Model: FIFO of filled banks (head is the bank the consumer reads or will read next).
    int q[$];
    bit m_pb, m_cb, m_run, m_err, m_ld;
    int m_start_at, m_fr;
`ifdef IFM_BANK_SCHED_PERF_EN
    logic [PERF_CNT_W-1:0] m_stall;
`endif

    typedef struct {
        bit         pd;
        bit         cd;
        logic [1:0] bf;
        bit         hold;
        bit         ps;
        bit         st;
        bit         cs;
        bit         busy;
        int         fr;
        bit         err;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_pb = 0; m_cb = 0; m_run = 0; m_err = 0; m_ld = 0;
        m_start_at = -1; m_fr = 0;
`ifdef IFM_BANK_SCHED_PERF_EN
        m_stall = '0;
`endif
    endtask

    task automatic check_all();
        logic [1:0] m_bf;
        m_bf = 2'b00;
        foreach (q[i]) m_bf[q[i]] = 1'b1;
        chk("bank_full", bus.bank_full, m_bf);
        chk("prod_hold", bus.prod_hold, q.size() == 2);
        chk("prod_bank_sel", bus.prod_bank_sel, m_pb);
        chk("cons_start", bus.cons_start, m_start_at == cyc);
        chk("cons_bank_sel", bus.cons_bank_sel, m_cb);
        chk("cons_busy", bus.cons_busy, m_run);
        chk("frames_consumed", bus.frames_consumed, m_fr);
        chk("layer_done", bus.layer_done, m_ld);
        chk("err_overrun", bus.err_overrun, m_err);
`ifdef IFM_BANK_SCHED_PERF_EN
        chk("stall_cycles", bus.stall_cycles, m_stall);
`endif
    endtask

    task automatic step(input bit pd, input bit cd);
        bit hold, st, prod_ok, cons_ok;
        @(negedge clk);
        bus.prod_done = pd;
        bus.cons_done = cd;
        #1;
        check_all();
        hold = (q.size() == 2);
        st   = (m_start_at == cyc);
        if (!m_run && m_start_at < 0 && q.size() > 0) m_start_at = cyc + START_DELAY;
        prod_ok = pd && !hold;
        cons_ok = cd && m_run;
        if (pd && !prod_ok) m_err = 1;
        if (cd && !cons_ok) m_err = 1;
`ifdef IFM_BANK_SCHED_PERF_EN
        if (m_ld) m_stall = '0;
        else if (hold && m_stall != '1) m_stall = m_stall + 1'b1;
`endif
        m_ld = 0;
        if (prod_ok) begin
            q.push_back(m_pb);
            m_pb = !m_pb;
        end
        if (cons_ok) begin
            void'(q.pop_front());
            m_cb  = !m_cb;
            m_run = 0;
            if (m_fr == NUM_FRAMES - 1) begin
                m_fr = 0;
                m_ld = 1;
            end else begin
                m_fr++;
            end
        end
        if (st) begin
            m_run      = 1;
            m_start_at = -1;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset         = 1'b0;
        bus.prod_done = 1'b0;
        bus.cons_done = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bus.prod_done = 1'b0;
        bus.cons_done = 1'b0;

        //           pd cd  bf     hold ps st cs busy fr err
        tbl[0]  = '{1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 2'b01, 0, 1, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 2'b01, 0, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 2'b01, 0, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 2'b01, 0, 1, 1, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 2'b01, 0, 1, 0, 0, 1, 0, 0};
        tbl[6]  = '{1, 0, 2'b11, 1, 0, 0, 0, 1, 0, 0};
        tbl[7]  = '{0, 1, 2'b11, 1, 0, 0, 0, 1, 0, 1};
        tbl[8]  = '{0, 0, 2'b10, 0, 0, 0, 1, 0, 1, 1};
        tbl[9]  = '{0, 0, 2'b10, 0, 0, 0, 1, 0, 1, 1};
        tbl[10] = '{0, 0, 2'b10, 0, 0, 0, 1, 0, 1, 1};
        tbl[11] = '{0, 0, 2'b10, 0, 0, 1, 1, 0, 1, 1};
        tbl[12] = '{1, 1, 2'b10, 0, 0, 0, 1, 1, 1, 1};
        tbl[13] = '{0, 0, 2'b01, 0, 1, 0, 0, 0, 2, 1};
        tbl[14] = '{0, 0, 2'b01, 0, 1, 0, 0, 0, 2, 1};
        tbl[15] = '{0, 0, 2'b01, 0, 1, 0, 0, 0, 2, 1};
        tbl[16] = '{0, 0, 2'b01, 0, 1, 1, 0, 0, 2, 1};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].pd, tbl[i].cd);
            chk("tbl_bank_full", bus.bank_full, tbl[i].bf);
            chk("tbl_prod_hold", bus.prod_hold, tbl[i].hold);
            chk("tbl_prod_sel", bus.prod_bank_sel, tbl[i].ps);
            chk("tbl_cons_start", bus.cons_start, tbl[i].st);
            chk("tbl_cons_sel", bus.cons_bank_sel, tbl[i].cs);
            chk("tbl_cons_busy", bus.cons_busy, tbl[i].busy);
            chk("tbl_frames", bus.frames_consumed, tbl[i].fr);
            chk("tbl_err", bus.err_overrun, tbl[i].err);
        end

        // Spurious cons_done while idle.
        do_reset();
        step(0, 1);
        step(0, 0);
        chk("spur_err", bus.err_overrun, 1);
        chk("spur_frames", bus.frames_consumed, 0);
        chk("spur_bank_full", bus.bank_full, 0);

        // Reset in the middle of the start delay.
        do_reset();
        step(1, 0);
        step(0, 0);
        step(0, 0);
        do_reset();
        chk("rst_bank_full", bus.bank_full, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 0);
            chk("rst_no_start", bus.cons_start, 0);
        end

        // Full pass with wrap and alternating banks.
        do_reset();
        for (int f = 0; f < NUM_FRAMES; f++) begin
            step(1, 0);
            chk("pass_frames", bus.frames_consumed, f);
            for (int k = 0; k < START_DELAY; k++) step(0, 0);
            step(0, 0);
            chk("pass_start", bus.cons_start, 1);
            chk("pass_bank", bus.cons_bank_sel, f % 2);
            step(0, 1);
            chk("pass_ld_low", bus.layer_done, 0);
        end
        step(0, 0);
        chk("pass_layer_done", bus.layer_done, 1);
        chk("pass_wrap", bus.frames_consumed, 0);
        step(0, 0);
        chk("pass_ld_once", bus.layer_done, 0);

`ifdef IFM_BANK_SCHED_PERF_EN
        do_reset();
        step(1, 0);
        step(1, 0);
        for (int k = 0; k < 20; k++) step(0, 0);
        step(0, 0);
        chk("perf_stall20", bus.stall_cycles, 20);
`endif

        // Randomized traffic, mostly legal, with occasional protocol errors.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit pd, cd;
            if (i % 500 == 499) do_reset();
            pd = (q.size() < 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
            cd = m_run ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
            step(pd, cd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ifm_bank_scheduler.md
Name: ifm_bank_scheduler

Overview:
- Ping-pong bank scheduler between a producer layer (e.g. conv1 writer) and a consumer layer (e.g. pool1 reader) that share two IFM memory banks.
- Tracks the full/free state of each bank and steers producer writes and consumer reads to the correct bank.
- Issues start pulses to the consumer, stalls the producer when no bank is free, and flags layer completion after NUM_FRAMES maps.

Parameters:
- NUM_FRAMES, 6, feature maps per layer pass.
- FRAME_CNT_W, $clog2(NUM_FRAMES+1), width of the frame counters.
- START_DELAY, 3, cycles between a bank becoming full and cons_start (covers the write-enable pipeline); legal range 1..15.
- PERF_CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- prod_done  in  1  one-cycle pulse: producer finished writing bank prod_bank_sel.
- prod_hold  out  1  high: no free bank, so the producer must not start or write.
- prod_bank_sel  out  1  bank the producer writes.
- cons_start  out  1  one-cycle pulse: consumer starts on bank cons_bank_sel.
- cons_done  in  1  one-cycle pulse: consumer finished reading its bank.
- cons_bank_sel  out  1  bank the consumer reads; stable from cons_start until cons_done.
- cons_busy  out  1  consumer owns a bank.
- bank_full  out  2  per-bank full flags.
- frames_consumed  out  FRAME_CNT_W  maps completed this pass.
- layer_done  out  1  one-cycle pulse when the last map is consumed.
- err_overrun  out  1  sticky protocol error flag.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - All outputs 0 and bank_full=2'b00.
  - Consumer FSM in C_IDLE; delay counter 0.
- Producer side:
  - prod_hold = bank_full[prod_bank_sel] (combinational from registers).
  - prod_done with prod_hold=0: set bank_full[prod_bank_sel] next cycle and toggle prod_bank_sel.
  - prod_done with prod_hold=1: ignored; sets err_overrun.
- Consumer FSM: C_IDLE -> C_WAIT -> C_RUN -> C_IDLE.
  - C_IDLE: if bank_full[cons_bank_sel]=1, load delay counter with START_DELAY-1 and go to C_WAIT.
  - C_WAIT: decrement; at 0, assert cons_start for exactly one cycle, set cons_busy, go to C_RUN.
  - C_RUN: on cons_done, clear bank_full[cons_bank_sel], toggle cons_bank_sel, clear cons_busy, increment frames_consumed, go to C_IDLE.
  - Latency: prod_done (cycle N) -> bank_full set at N+1 -> cons_start at N+1+START_DELAY, when the consumer is idle and this is its bank.
- cons_done outside C_RUN: ignored; sets err_overrun.
- prod_done and cons_done in the same cycle: both take effect. They always target different banks, except when both banks are full, in which case prod_done is the overrun case above.
- Frame-count wrap: when frames_consumed reaches NUM_FRAMES-1 and cons_done arrives:
  - pulse layer_done;
  - frames_consumed wraps to 0;
  - bank selects are not reset, so banks continue ping-ponging.
- err_overrun clears only on reset.
- Reset asserted mid-operation: every flag and FSM returns to its reset value immediately. In-flight producer or consumer activity is discarded, not resumed.
- Ordering: FIFO over banks. The consumer always reads banks in the same order the producer filled them.

Optional Feature:
- Macro: IFM_BANK_SCHED_PERF_EN.
- When defined:
  - adds output stall_cycles [PERF_CNT_W-1:0];
  - counts cycles with prod_hold=1, saturating at all-ones;
  - clears on reset and on layer_done.
- When undefined: the port and counter are absent and all other behaviour is identical.

Decomposition:
- Shared package lenet_ctrl_pkg holds:
  - consumer FSM state encodings C_IDLE/C_WAIT/C_RUN (2-bit);
  - the bank index type (1-bit);
  - the START_DELAY default.
- One natural sub-module, ifm_bank_start_timer: the loadable down-counter with its zero tick, instantiated for C_WAIT.

Test Plan:
- Single frame, START_DELAY=3: prod_done at cycle 10 -> bank_full=01 at 11, cons_start pulse at 14 with cons_bank_sel=0, prod_bank_sel=1, prod_hold=0.
- Producer outruns consumer: two prod_done pulses with no cons_done -> bank_full=11, prod_hold=1. A third prod_done -> err_overrun=1 and bank_full unchanged.
- Simultaneous events: bank 0 in C_RUN, bank 1 free; prod_done and cons_done in the same cycle -> next cycle bank_full=10, cons_bank_sel=1, START_DELAY later cons_start on bank 1.
- Full pass, NUM_FRAMES=6: six fill/drain cycles -> frames_consumed counts 1..5, then layer_done pulses once and the count returns to 0; the bank sequence alternates 0,1,0,1,0,1.
- Spurious cons_done in C_IDLE -> err_overrun=1, no state or counter change. Reset pulse mid-C_WAIT -> no cons_start, all outputs 0.
- With IFM_BANK_SCHED_PERF_EN defined: hold prod_hold high for 20 cycles -> stall_cycles=20. After layer_done -> stall_cycles=0.
